pu_policy_loader: RTL and testbench

- AXI4-Lite master that programs the ProtectionUnit configuration slave from a policy table.
- On `start`, walks table entries 0..`num_entries`-1; for each entry, writes the data word to the given register offset, then reads it back and compares under a per-entry mask.
- Reports done/error status to the system controller.
- Replaces ad-hoc software or VIP-driven config writes such as config register 0x00 and policy register 0x44.

---
 rtl/pu_policy_loader.sv | 271 +++++++++++++++++++++++++++
 tb/tb_pu_policy_loader.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_policy_loader.sv
// AXI4-Lite master that walks a policy table and programs the ProtectionUnit
// config slave, verifying each entry by masked readback unless its mask is 0.
module pu_policy_loader #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [IDX_W:0]        num_entries,
    output logic                  tbl_rd_en,
    output logic [IDX_W-1:0]      tbl_idx,
    input  logic [ADDR_W-1:0]     tbl_addr,
    input  logic [DATA_W-1:0]     tbl_data,
    input  logic [DATA_W-1:0]     tbl_mask,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [IDX_W-1:0]      err_idx
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX1_W = IDX_W + 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_RESP = 2'd1;
    localparam logic [1:0] ERR_CMP  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_TBL,
        S_WR,
        S_BRESP,
        S_RD,
        S_RDATA,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t state;
    state_t next_state;

    logic [IDX_W-1:0]  idx;
    logic [IDX1_W-1:0] num_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] mask_q;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              aw_done_q;
    logic              w_done_q;

    logic              accept;
    logic [1:0]        err_nxt;
    logic              aw_ok;
    logic              w_ok;
    logic              b_hs;
    logic              ar_hs;
    logic              r_hs;
    logic              tmo_hit;
    logic              last_entry;
    logic              rd_mismatch;

    logic              tbl_rd_en_d;
    logic              awvalid_d;
    logic              wvalid_d;
    logic              bready_d;
    logic              arvalid_d;
    logic              rready_d;
    logic              busy_d;
    logic              done_d;
    logic              error_d;

    // Handshake and phase-condition decode
    assign aw_ok       = aw_done_q | (m_axi_awvalid & m_axi_awready);
    assign w_ok        = w_done_q  | (m_axi_wvalid  & m_axi_wready);
    assign b_hs        = m_axi_bvalid  & m_axi_bready;
    assign ar_hs       = m_axi_arvalid & m_axi_arready;
    assign r_hs        = m_axi_rvalid  & m_axi_rready;
    assign tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign last_entry  = ((IDX1_W'(idx) + IDX1_W'(1)) == num_q);
    assign rd_mismatch = (((m_axi_rdata ^ data_q) & mask_q) != '0);

    // Payload outputs come straight from the captured entry registers
    assign tbl_idx      = idx;
    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = data_q;
    assign m_axi_wstrb  = {STRB_W{m_axi_wvalid}};

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        err_nxt    = 2'd0;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = (num_entries == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: next_state = S_TBL;
            S_TBL:   next_state = S_WR;
            S_WR: begin
                if (aw_ok && w_ok) begin
                    next_state = S_BRESP;
                end else if (tmo_hit) begin
                    next_state = S_ERROR;
                    err_nxt    = ERR_TMO;
                end
            end
            S_BRESP: begin
                if (b_hs) begin
                    if (m_axi_bresp != 2'b00) begin
                        next_state = S_ERROR;
                        err_nxt    = ERR_RESP;
                    end else if (mask_q == '0) begin
                        next_state = S_NEXT;
                    end else begin
                        next_state = S_RD;
                    end
                end else if (tmo_hit) begin
                    next_state = S_ERROR;
                    err_nxt    = ERR_TMO;
                end
            end
            S_RD: begin
                if (ar_hs) begin
                    next_state = S_RDATA;
                end else if (tmo_hit) begin
                    next_state = S_ERROR;
                    err_nxt    = ERR_TMO;
                end
            end
            S_RDATA: begin
                if (r_hs) begin
                    if (m_axi_rresp != 2'b00) begin
                        next_state = S_ERROR;
                        err_nxt    = ERR_RESP;
                    end else if (rd_mismatch) begin
                        next_state = S_ERROR;
                        err_nxt    = ERR_CMP;
                    end else begin
                        next_state = S_NEXT;
                    end
                end else if (tmo_hit) begin
                    next_state = S_ERROR;
                    err_nxt    = ERR_TMO;
                end
            end
            S_NEXT:  next_state = last_entry ? S_DONE : S_FETCH;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state, so every output is a flop
    always_comb begin
        tbl_rd_en_d = (next_state == S_FETCH);
        awvalid_d   = (next_state == S_WR) && !aw_ok;
        wvalid_d    = (next_state == S_WR) && !w_ok;
        bready_d    = (next_state == S_BRESP);
        arvalid_d   = (next_state == S_RD);
        rready_d    = (next_state == S_RDATA);
        busy_d      = !(next_state inside {S_IDLE, S_DONE, S_ERROR});
        done_d      = (next_state == S_DONE);
        error_d     = (next_state == S_ERROR);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tbl_rd_en     <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            tbl_rd_en     <= tbl_rd_en_d;
            m_axi_awvalid <= awvalid_d;
            m_axi_wvalid  <= wvalid_d;
            m_axi_bready  <= bready_d;
            m_axi_arvalid <= arvalid_d;
            m_axi_rready  <= rready_d;
            busy          <= busy_d;
            done          <= done_d;
            error         <= error_d;
        end
    end

    // Per-phase watchdog; restarts on every state change
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tmo_cnt <= '0;
        end else if (next_state != state) begin
            tmo_cnt <= '0;
        end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Entry bookkeeping, captured table entry and error status
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            idx       <= '0;
            num_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            err_code  <= 2'd0;
            err_idx   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            aw_done_q <= (next_state == S_WR) && aw_ok;
            w_done_q  <= (next_state == S_WR) && w_ok;
            if (accept) begin
                idx      <= '0;
                num_q    <= num_entries;
                err_code <= 2'd0;
                err_idx  <= '0;
            end else if (state == S_NEXT) begin
                idx <= idx + IDX_W'(1);
            end
            if (state == S_TBL) begin
                addr_q <= tbl_addr;
                data_q <= tbl_data;
                mask_q <= tbl_mask;
            end
            if ((next_state == S_ERROR) && (state != S_ERROR)) begin
                err_code <= err_nxt;
                err_idx  <= idx;
            end
        end
    end

endmodule

// File: tb/tb_pu_policy_loader.sv
// Randomized bench for pu_policy_loader: behavioural AXI-Lite slave and table,
// with a per-run outcome model derived from the entry list and slave config.
module tb_pu_policy_loader;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned TIMEOUT = 255;

    logic              aclk = 1'b0;
    logic              areset;
    logic              start;
    logic [IDX_W:0]    num_entries;
    logic              tbl_rd_en;
    logic [IDX_W-1:0]  tbl_idx;
    logic [ADDR_W-1:0] tbl_addr;
    logic [31:0]       tbl_data;
    logic [31:0]       tbl_mask;
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [31:0]       m_axi_wdata;
    logic [3:0]        m_axi_wstrb;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid;
    logic              m_axi_bready;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [31:0]       m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rvalid;
    logic              m_axi_rready;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;
    logic [IDX_W-1:0]  err_idx;

    pu_policy_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .aclk(aclk), .areset(areset), .start(start), .num_entries(num_entries),
        .tbl_rd_en(tbl_rd_en), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data), .tbl_mask(tbl_mask),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .err_idx(err_idx)
    );

    always #5 aclk = ~aclk;

    // Policy table contents and slave behaviour knobs
    logic [7:0]  t_addr [16];
    logic [31:0] t_data [16];
    logic [31:0] t_mask [16];
    int aw_delay, w_delay, b_delay, ar_delay, r_delay;
    bit b_never;
    int bresp_err_at, rresp_err_at, corrupt_addr;
    logic [31:0] flip;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return {tbl_rd_en, tbl_idx, m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb,
                m_axi_wvalid, m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
                busy, done, error, err_code, err_idx};
    endfunction

    // Table: response appears only in the cycle after the read strobe
    bit         tbl_pend = 1'b0;
    logic [3:0] tbl_pidx;
    always @(negedge aclk) begin
        if (tbl_pend) begin
            tbl_addr = t_addr[tbl_pidx];
            tbl_data = t_data[tbl_pidx];
            tbl_mask = t_mask[tbl_pidx];
        end else begin
            tbl_addr = 8'($urandom);
            tbl_data = $urandom;
            tbl_mask = $urandom;
        end
        tbl_pend = tbl_rd_en;
        tbl_pidx = tbl_idx;
    end

    // AXI-Lite slave with register storage, stall knobs and protocol monitor
    logic [31:0] mem [256];
    logic [7:0]  wr_log_a [$];
    logic [31:0] wr_log_d [$];
    bit          aw_v_q, w_v_q, ar_v_q, b_r_q, r_r_q, got_aw, got_w, b_pend, r_pend;
    logic [7:0]  aw_a_q, ar_a_q, wa, ra;
    logic [31:0] w_d_q, wd;
    logic [1:0]  cur_bresp, cur_rresp;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    int wr_count, rd_count, viol, aw_hi, w_hi, bready_hi, ar_seen, any_axi;

    always @(negedge aclk) begin
        if (areset) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
            m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
            got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            aw_v_q = 0; w_v_q = 0; ar_v_q = 0; b_r_q = 0; r_r_q = 0;
        end else begin
            if (aw_v_q && !m_axi_awready && (!m_axi_awvalid || m_axi_awaddr != aw_a_q)) viol++;
            if (w_v_q && !m_axi_wready && (!m_axi_wvalid || m_axi_wdata != w_d_q)) viol++;
            if (ar_v_q && !m_axi_arready && (!m_axi_arvalid || m_axi_araddr != ar_a_q)) viol++;
            if (m_axi_wvalid && m_axi_wstrb != 4'hF) viol++;
            // handshakes completed at the preceding rising edge
            if (aw_v_q && m_axi_awready) begin got_aw = 1; wa = aw_a_q; m_axi_awready = 0; aw_wait = 0; end
            if (w_v_q && m_axi_wready) begin got_w = 1; wd = w_d_q; m_axi_wready = 0; w_wait = 0; end
            if (m_axi_bvalid && b_r_q) begin m_axi_bvalid = 0; m_axi_bresp = 0; b_pend = 0; end
            if (ar_v_q && m_axi_arready) begin
                r_pend = 1; ra = ar_a_q; m_axi_arready = 0; ar_wait = 0; r_wait = 0;
                cur_rresp = (rd_count == rresp_err_at) ? 2'b10 : 2'b00;
                rd_count++;
            end
            if (m_axi_rvalid && r_r_q) begin m_axi_rvalid = 0; m_axi_rresp = 0; r_pend = 0; end
            if (got_aw && got_w) begin
                mem[wa] = wd;
                wr_log_a.push_back(wa);
                wr_log_d.push_back(wd);
                cur_bresp = (wr_count == bresp_err_at) ? 2'b10 : 2'b00;
                wr_count++;
                got_aw = 0; got_w = 0; b_pend = 1; b_wait = 0;
            end
            if (m_axi_awvalid && !got_aw && !m_axi_awready) begin
                if (aw_wait >= aw_delay) m_axi_awready = 1; else aw_wait++;
            end
            if (m_axi_wvalid && !got_w && !m_axi_wready) begin
                if (w_wait >= w_delay) m_axi_wready = 1; else w_wait++;
            end
            if (b_pend && !m_axi_bvalid && !b_never) begin
                if (b_wait >= b_delay) begin m_axi_bvalid = 1; m_axi_bresp = cur_bresp; end
                else b_wait++;
            end
            if (m_axi_arvalid && !r_pend && !m_axi_arready) begin
                if (ar_wait >= ar_delay) m_axi_arready = 1; else ar_wait++;
            end
            if (r_pend && !m_axi_rvalid) begin
                if (r_wait >= r_delay) begin
                    m_axi_rvalid = 1;
                    m_axi_rdata  = mem[ra] ^ ((int'(ra) == corrupt_addr) ? flip : 32'h0);
                    m_axi_rresp  = cur_rresp;
                end else r_wait++;
            end
            aw_hi += int'(m_axi_awvalid);
            w_hi += int'(m_axi_wvalid);
            bready_hi += int'(m_axi_bready);
            ar_seen += int'(m_axi_arvalid);
            any_axi += int'(m_axi_awvalid | m_axi_wvalid | m_axi_bready | m_axi_arvalid | m_axi_rready);
            aw_v_q = m_axi_awvalid; aw_a_q = m_axi_awaddr;
            w_v_q = m_axi_wvalid; w_d_q = m_axi_wdata;
            ar_v_q = m_axi_arvalid; ar_a_q = m_axi_araddr;
            b_r_q = m_axi_bready; r_r_q = m_axi_rready;
        end
    end

    task automatic cfg_default();
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
        b_never = 0; bresp_err_at = -1; rresp_err_at = -1; corrupt_addr = -1; flip = 0;
    endtask

    // Outcome of a run from the table and slave knobs (term: 1 = done, 2 = error)
    task automatic model(input int n, output int term, output int code, output int eidx,
                         output int nwr, output int nrd, output int cyc);
        logic [31:0] rv;
        term = 1; code = 0; eidx = 0; nwr = 0; nrd = 0; cyc = 0;
        for (int i = 0; i < n; i++) begin
            nwr++;
            cyc += 5;
            if (b_never) begin term = 2; code = 3; eidx = i; return; end
            if (nwr - 1 == bresp_err_at) begin term = 2; code = 1; eidx = i; return; end
            if (t_mask[i] == 32'h0) continue;
            nrd++;
            cyc += 2;
            if (nrd - 1 == rresp_err_at) begin term = 2; code = 1; eidx = i; return; end
            rv = t_data[i] ^ ((int'(t_addr[i]) == corrupt_addr) ? flip : 32'h0);
            if (((rv ^ t_data[i]) & t_mask[i]) != 32'h0) begin term = 2; code = 2; eidx = i; return; end
        end
    endtask

    int last_cyc;

    task automatic run(input string tag, input int n, input bit chk_cyc);
        int term, code, eidx, nwr, nrd, ecyc, cyc, busy_cyc, limit;
        model(n, term, code, eidx, nwr, nrd, ecyc);
        limit = 100 * n + 2 * TIMEOUT + 50;
        @(negedge aclk);
        #1;
        wr_log_a.delete(); wr_log_d.delete();
        wr_count = 0; rd_count = 0; viol = 0; aw_hi = 0; w_hi = 0;
        bready_hi = 0; ar_seen = 0; any_axi = 0;
        start = 1'b1;
        num_entries = 5'(n);
        @(negedge aclk);
        start = 1'b0;
        cyc = 1;
        busy_cyc = int'(busy);
        while (!(done || error) && cyc < limit) begin
            @(negedge aclk);
            start = 1'b0;
            cyc++;
            busy_cyc += int'(busy);
            if (busy && $urandom_range(0, 19) == 0) begin
                start = 1'b1;
                num_entries = 5'($urandom_range(0, 16));
            end
        end
        last_cyc = cyc;
        chk($sformatf("%s.finished", tag), cyc < limit, 1);
        chk($sformatf("%s.term", tag), {done, error}, (term == 1) ? 2'b10 : 2'b01);
        chk($sformatf("%s.err_code", tag), err_code, code);
        chk($sformatf("%s.err_idx", tag), err_idx, eidx);
        chk($sformatf("%s.writes", tag), wr_count, nwr);
        chk($sformatf("%s.reads", tag), rd_count, nrd);
        for (int i = 0; i < nwr && i < wr_log_a.size(); i++)
            chk($sformatf("%s.wr%0d", tag, i), {wr_log_a[i], wr_log_d[i]}, {t_addr[i], t_data[i]});
        chk($sformatf("%s.protocol", tag), viol, 0);
        if (chk_cyc && term == 1)
            chk($sformatf("%s.cycles", tag), busy_cyc, ecyc);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        #1 areset = 1'b0;
    endtask

    initial begin
        int cnt, n;
        areset = 1'b1;
        start = 1'b0;
        num_entries = '0;
        cfg_default();
        #1 chk("reset.outputs", outs(), 0);
        repeat (3) @(negedge aclk);
        #1 areset = 1'b0;
        chk("reset.held", outs(), 0);

        t_addr[0] = 8'h00; t_data[0] = 32'hF0F0F0F0; t_mask[0] = 32'hFFFFFFFF;
        t_addr[1] = 8'h44; t_data[1] = 32'h0000000C; t_mask[1] = 32'hFFFFFFFF;
        run("two", 2, 1);

        aw_delay = 3;
        run("awdly", 1, 0);
        chk("awdly.aw_cycles", aw_hi, 4);
        chk("awdly.w_cycles", w_hi, 1);
        cfg_default();

        corrupt_addr = 32'h44; flip = 32'h1;
        t_mask[1] = 32'h0000000F;
        run("cmp_lo", 2, 0);
        t_mask[1] = 32'hFFFFFFF0;
        run("cmp_hi", 2, 1);
        cfg_default();
        t_mask[1] = 32'hFFFFFFFF;

        bresp_err_at = 0;
        run("bresp", 2, 0);
        chk("bresp.no_ar", ar_seen, 0);
        cfg_default();

        run("zero", 0, 1);
        chk("zero.latency", last_cyc, 1);
        chk("zero.no_axi", any_axi, 0);

        b_never = 1;
        run("tmo", 1, 0);
        chk("tmo.bready_cycles", bready_hi, TIMEOUT);
        cfg_default();
        do_reset();

        aw_delay = 20; w_delay = 20;
        @(negedge aclk);
        #1 start = 1'b1; num_entries = 5'd2;
        @(negedge aclk);
        start = 1'b0;
        cnt = 0;
        while (!m_axi_awvalid && cnt < 50) begin @(negedge aclk); cnt++; end
        chk("rst.in_wr", m_axi_awvalid, 1);
        #2 areset = 1'b1;
        #1 chk("rst.outputs", outs(), 0);
        @(negedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        chk("rst.idle", outs(), 0);
        cfg_default();
        run("rst.rerun", 2, 1);

        for (int r = 0; r < 25; r++) begin
            n = (r == 0) ? 16 : $urandom_range(1, 16);
            for (int i = 0; i < 16; i++) begin
                t_addr[i] = 8'($urandom);
                t_data[i] = $urandom;
                t_mask[i] = ($urandom_range(0, 3) == 0) ? 32'h0 :
                            ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : $urandom;
            end
            cfg_default();
            if ($urandom_range(0, 2) != 0) begin
                aw_delay = $urandom_range(0, 4); w_delay = $urandom_range(0, 4);
                b_delay = $urandom_range(0, 4); ar_delay = $urandom_range(0, 4);
                r_delay = $urandom_range(0, 4);
            end
            if ($urandom_range(0, 3) == 0) bresp_err_at = $urandom_range(0, n - 1);
            if ($urandom_range(0, 3) == 0) rresp_err_at = $urandom_range(0, n - 1);
            if ($urandom_range(0, 2) == 0) begin
                corrupt_addr = int'(t_addr[$urandom_range(0, n - 1)]);
                flip = $urandom | 32'h1;
            end
            run($sformatf("rnd%0d", r), n,
                (aw_delay + w_delay + b_delay + ar_delay + r_delay) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
